// File: rtl/video_timing_pkg.sv
// video_timing_pkg: mode/state enums and the per-mode video timing table
package video_timing_pkg;
  typedef enum logic [1:0] {
    MODE_800X600  = 2'd0,
    MODE_1024X768 = 2'd1,
    MODE_1280X720 = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;
  typedef enum logic [1:0] {IDLE, WAIT_VS, QUIESCE, RELEASE} state_e;
  typedef struct packed {
    logic [11:0] h_total;
    logic [11:0] h_sync;
    logic [11:0] h_bporch;
    logic [11:0] h_res;
    logic [11:0] v_total;
    logic [11:0] v_sync;
    logic [11:0] v_bporch;
    logic [11:0] v_res;
  } timing_t;
  localparam timing_t TIMING_800X600 = '{12'd1056, 12'd128, 12'd88, 12'd800, 12'd628, 12'd4, 12'd23, 12'd600};
  localparam timing_t TIMING_1024X768 = '{12'd1344, 12'd136, 12'd160, 12'd1024, 12'd806, 12'd6, 12'd29, 12'd768};
  localparam timing_t TIMING_1280X720 = '{12'd1650, 12'd40, 12'd220, 12'd1280, 12'd750, 12'd5, 12'd20, 12'd720};
  function automatic timing_t timing_of(input mode_e m);
    return (m == MODE_800X600) ? TIMING_800X600 : (m == MODE_1024X768) ? TIMING_1024X768 : TIMING_1280X720;
  endfunction
endpackage

// File: rtl/video_mode_ctrl_if.sv
// video_mode_ctrl_if: mode request valid/ready handshake
interface video_mode_ctrl_if;
  import video_timing_pkg::*;
  mode_e mode_req;
  logic  req_vld;
  logic  req_rdy;
  modport master (output mode_req, req_vld, input req_rdy);
  modport slave (input mode_req, req_vld, output req_rdy);
endinterface

// File: rtl/vs_edge_det.sv
// vs_edge_det: VS falling-edge pulse against the registered previous VS sample
module vs_edge_det (
  input  logic I_clk,
  input  logic I_rst_n,
  input  logic I_vs,
  output logic O_fall
);
  logic vs_q;
  // previous-cycle VS; cleared at reset so no edge is seen on the first cycle
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) vs_q <= 1'b0;
    else vs_q <= I_vs;
  end
  assign O_fall = vs_q & ~I_vs;
endmodule

// File: rtl/video_mode_ctrl.sv
// video_mode_ctrl: sequences video mode changes with a VS-aligned quiesce of the tx reset; VIDEO_MODE_CTRL_AUTO_CYCLE_EN enables automatic pattern cycling
module video_mode_ctrl
  import video_timing_pkg::*;
#(
  parameter int QUIESCE_CYC  = 16,
  parameter int VS_TIMEOUT_W = 20
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  video_mode_ctrl_if.slave req_if,
  input  logic             I_vs,
  input  logic [2:0]       I_pat_sel,
  output logic [11:0]      O_h_total,
  output logic [11:0]      O_h_sync,
  output logic [11:0]      O_h_bporch,
  output logic [11:0]      O_h_res,
  output logic [11:0]      O_v_total,
  output logic [11:0]      O_v_sync,
  output logic [11:0]      O_v_bporch,
  output logic [11:0]      O_v_res,
  output logic [2:0]       O_pat_mode,
  output logic             O_tx_rst_n,
  output logic [1:0]       O_cur_mode,
  output logic             O_done,
  output logic             O_err
);
  state_e                  state, state_nx;
  mode_e                   cur_mode, req_mode;
  timing_t                 tim;
  logic [7:0]              q_cnt;
  logic [VS_TIMEOUT_W-1:0] to_cnt;
  logic                    vs_fall, accept, done_nx, err_nx;

  vs_edge_det u_vs_edge_det (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .I_vs    (I_vs),
    .O_fall  (vs_fall)
  );

  assign accept = (state == IDLE) && req_if.req_vld;
  assign req_if.req_rdy = (state == IDLE);
  assign {O_h_total, O_h_sync, O_h_bporch, O_h_res, O_v_total, O_v_sync, O_v_bporch, O_v_res} = tim;
  assign O_cur_mode = cur_mode;

  // next state and one-cycle done/err pulses
  always_comb begin
    state_nx = state;
    done_nx = 1'b0;
    err_nx = 1'b0;
    case (state)
      IDLE: begin
        err_nx = accept && (req_if.mode_req == MODE_RSVD);
        done_nx = accept && (req_if.mode_req == cur_mode);
        if (accept && req_if.mode_req != MODE_RSVD && req_if.mode_req != cur_mode) state_nx = WAIT_VS;
      end
      WAIT_VS: if (vs_fall || &to_cnt) state_nx = QUIESCE;
      QUIESCE: if (q_cnt == 8'd0) state_nx = RELEASE;
      default: state_nx = IDLE;
    endcase
    done_nx = done_nx | (state_nx == RELEASE);
  end

  // state, counters, latched request and registered outputs; timing only moves on quiesce entry
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state <= QUIESCE;
      q_cnt <= 8'(QUIESCE_CYC - 1);
      to_cnt <= '0;
      req_mode <= MODE_1280X720;
      cur_mode <= MODE_1280X720;
      tim <= TIMING_1280X720;
      O_tx_rst_n <= 1'b0;
      O_done <= 1'b0;
      O_err <= 1'b0;
    end else begin
      state <= state_nx;
      q_cnt <= (state == QUIESCE) ? q_cnt - 8'd1 : 8'(QUIESCE_CYC - 1);
      to_cnt <= (state == WAIT_VS) ? to_cnt + 1'b1 : '0;
      if (state == IDLE && state_nx == WAIT_VS) req_mode <= req_if.mode_req;
      if (state == WAIT_VS && state_nx == QUIESCE) begin
        cur_mode <= req_mode;
        tim <= timing_of(req_mode);
      end
      O_tx_rst_n <= (state_nx != QUIESCE);
      O_done <= done_nx;
      O_err <= err_nx;
    end
  end

`ifdef VIDEO_MODE_CTRL_AUTO_CYCLE_EN
  logic [9:0] frame_cnt;
  // frames since the last reconfiguration; the top bits step the pattern every 256 frames
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) frame_cnt <= '0;
    else if (state == QUIESCE) frame_cnt <= '0;
    else if (vs_fall) frame_cnt <= frame_cnt + 10'd1;
  end
  assign O_pat_mode = {1'b0, frame_cnt[9:8]};
`else
  // pattern select is taken once per frame so it never changes mid-frame
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) O_pat_mode <= 3'd0;
    else if (vs_fall) O_pat_mode <= I_pat_sel;
  end
`endif
endmodule

// File: tb/tb_video_mode_ctrl.sv
// tb_video_mode_ctrl: directed plus randomized checks of video_mode_ctrl against a table/rule model
module tb_video_mode_ctrl;
  import video_timing_pkg::*;
  localparam int QC = 16;
  localparam int TW = 8;
  logic clk = 1'b0, rst_n = 1'b0, vs = 1'b0;
  logic [2:0] pat_sel = 3'd0;
  logic [11:0] h_total, h_sync, h_bporch, h_res, v_total, v_sync, v_bporch, v_res;
  logic [2:0] pat_mode;
  logic tx_rst_n, done, err;
  logic [1:0] cur_mode;
  int n_chk = 0, n_err = 0;
  int exp_mode = 2, exp_pat = 0, exp_edges = 0;
  int t_ht[3] = '{1056, 1344, 1650};
  int t_hs[3] = '{128, 136, 40};
  int t_hb[3] = '{88, 160, 220};
  int t_hr[3] = '{800, 1024, 1280};
  int t_vt[3] = '{628, 806, 750};
  int t_vs[3] = '{4, 6, 5};
  int t_vb[3] = '{23, 29, 20};
  int t_vr[3] = '{600, 768, 720};

  video_mode_ctrl_if req_if ();

  video_mode_ctrl #(.QUIESCE_CYC(QC), .VS_TIMEOUT_W(TW)) dut (
    .I_clk      (clk),
    .I_rst_n    (rst_n),
    .req_if     (req_if),
    .I_vs       (vs),
    .I_pat_sel  (pat_sel),
    .O_h_total  (h_total),
    .O_h_sync   (h_sync),
    .O_h_bporch (h_bporch),
    .O_h_res    (h_res),
    .O_v_total  (v_total),
    .O_v_sync   (v_sync),
    .O_v_bporch (v_bporch),
    .O_v_res    (v_res),
    .O_pat_mode (pat_mode),
    .O_tx_rst_n (tx_rst_n),
    .O_cur_mode (cur_mode),
    .O_done     (done),
    .O_err      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat_exp();
`ifdef VIDEO_MODE_CTRL_AUTO_CYCLE_EN
    return 32'(((exp_edges % 1024) / 256));
`else
    return 32'(exp_pat);
`endif
  endfunction

  task automatic check_timing(input string tag);
    chk({tag, "_h_total"}, h_total, t_ht[exp_mode]);
    chk({tag, "_h_sync"}, h_sync, t_hs[exp_mode]);
    chk({tag, "_h_bporch"}, h_bporch, t_hb[exp_mode]);
    chk({tag, "_h_res"}, h_res, t_hr[exp_mode]);
    chk({tag, "_v_total"}, v_total, t_vt[exp_mode]);
    chk({tag, "_v_sync"}, v_sync, t_vs[exp_mode]);
    chk({tag, "_v_bporch"}, v_bporch, t_vb[exp_mode]);
    chk({tag, "_v_res"}, v_res, t_vr[exp_mode]);
    chk({tag, "_cur_mode"}, cur_mode, exp_mode);
  endtask

  task automatic wait_rise(input string tag);
    int n = 0;
    while (tx_rst_n !== 1'b1 && n < 4000) begin
      tick();
      n++;
    end
    chk({tag, "_quiesce_len"}, n, QC);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_pat"}, pat_mode, pat_exp());
    tick();
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_rdy"}, req_if.req_rdy, 1);
  endtask

  task automatic make_fall(input logic [2:0] sel);
    vs = 1'b1;
    pat_sel = sel;
    tick();
    vs = 1'b0;
    tick();
    exp_pat = sel;
    exp_edges++;
  endtask

  // kind: 0 = VS falls d cycles into WAIT_VS, 1 = VS held low (timeout), 2 = fall coincident with acceptance
  task automatic request(input int m, input int kind, input int d);
    int n = 0;
    logic [2:0] sel;
    while (req_if.req_rdy !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk("rdy_before_req", req_if.req_rdy, 1);
    sel = 3'($urandom);
    if (kind == 2) begin
      vs = 1'b1;
      tick();
    end
    req_if.mode_req = mode_e'(2'(m));
    req_if.req_vld = 1'b1;
    if (kind == 2) begin
      pat_sel = sel;
      vs = 1'b0;
    end
    tick();
    req_if.req_vld = 1'b0;
    if (kind == 2) begin
      exp_pat = sel;
      exp_edges++;
    end
    if (m == 3) begin
      chk("rsvd_err", err, 1);
      chk("rsvd_done", done, 0);
      chk("rsvd_rdy", req_if.req_rdy, 1);
      chk("rsvd_tx", tx_rst_n, 1);
      check_timing("rsvd");
      tick();
      chk("rsvd_err_clr", err, 0);
      chk("rsvd_pat", pat_mode, pat_exp());
    end else if (m == exp_mode) begin
      chk("same_done", done, 1);
      chk("same_err", err, 0);
      chk("same_rdy", req_if.req_rdy, 1);
      chk("same_tx", tx_rst_n, 1);
      tick();
      chk("same_done_clr", done, 0);
      chk("same_tx_hold", tx_rst_n, 1);
    end else begin
      chk("wait_rdy", req_if.req_rdy, 0);
      chk("wait_tx", tx_rst_n, 1);
      check_timing("wait_old");
      if (kind == 0) begin
        vs = 1'b1;
        repeat (d) tick();
        chk("pre_edge_tx", tx_rst_n, 1);
        chk("pre_edge_h_total", h_total, t_ht[exp_mode]);
        pat_sel = sel;
        vs = 1'b0;
        tick();
        exp_pat = sel;
      end else begin
        n = 0;
        while (tx_rst_n !== 1'b0 && n < 4000) begin
          tick();
          n++;
        end
        chk("timeout_len", n, 1 << TW);
      end
      exp_mode = m;
      exp_edges = 0;
      chk("quiesce_entry_tx", tx_rst_n, 0);
      check_timing("quiesce_entry");
      wait_rise("reconfig");
    end
  endtask

  initial begin
    int n;
    req_if.mode_req = MODE_1280X720;
    req_if.req_vld = 1'b0;
    repeat (3) tick();
    chk("rst_tx", tx_rst_n, 0);
    chk("rst_rdy", req_if.req_rdy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pat", pat_mode, 0);
    check_timing("rst");
    rst_n = 1'b1;
    wait_rise("rst_release");
    check_timing("after_rst");
    request(2, 1, 0);
    request(0, 0, 99);
    request(3, 1, 0);
    request(1, 1, 0);
    request(2, 2, 0);
    repeat (3) begin
      make_fall(3'($urandom));
      chk("pat_idle", pat_mode, pat_exp());
    end
    repeat (12) request(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), int'($urandom_range(1, 100)));
    n = 0;
    while (req_if.req_rdy !== 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    req_if.mode_req = mode_e'(2'((exp_mode + 1) % 3));
    req_if.req_vld = 1'b1;
    tick();
    req_if.req_vld = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    exp_mode = 2;
    exp_pat = 0;
    exp_edges = 0;
    chk("midrst_tx", tx_rst_n, 0);
    chk("midrst_rdy", req_if.req_rdy, 0);
    check_timing("midrst");
    rst_n = 1'b1;
    wait_rise("midrst_release");
    make_fall(3'd5);
    repeat (300) tick();
    chk("midrst_no_reconfig_tx", tx_rst_n, 1);
    chk("midrst_no_reconfig_rdy", req_if.req_rdy, 1);
    check_timing("midrst_final");
`ifdef VIDEO_MODE_CTRL_AUTO_CYCLE_EN
    for (int i = 0; i < 1100; i++) begin
      make_fall(3'($urandom));
      if (exp_edges % 256 == 0 || exp_edges % 256 == 255) chk("auto_pat", pat_mode, pat_exp());
    end
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
